// File: rtl/fifo_route_pkg.sv
// Shared types and helpers for the FIFO route switch (no logic of its own).
// Latency: n/a. Backpressure: n/a.
// Route decode windows are expressed on 32-bit values so any SEL_W up to 32 fits.
package fifo_route_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [31:0] NO_ROUTE      = '1;
  localparam logic [7:0]  DEF_UART_BASE = 8'h00;
  localparam logic [7:0]  DEF_SPI_BASE  = 8'h10;

  function automatic logic in_window(input int unsigned sel, input int unsigned base,
                                     input int unsigned n);
    return (sel >= base) && ((sel - base) < n);
  endfunction

  function automatic logic sel_valid(input int unsigned sel, input int unsigned uart_base,
                                     input int unsigned spi_base, input int unsigned nch);
    return in_window(sel, uart_base, nch) || in_window(sel, spi_base, nch);
  endfunction

endpackage

// File: rtl/fifo_route_decode.sv
// Maps a route selector to {uart_hit, spi_hit, one-hot channel}.
// Latency: combinational. Backpressure: none.
// Overlapping windows resolve in favour of UART.
module fifo_route_decode
  import fifo_route_pkg::*;
#(
  parameter int              NCH       = 4,
  parameter int              SEL_W     = 8,
  parameter logic [SEL_W-1:0] UART_BASE = SEL_W'(DEF_UART_BASE),
  parameter logic [SEL_W-1:0] SPI_BASE  = SEL_W'(DEF_SPI_BASE)
) (
  input  logic [SEL_W-1:0] cur_sel,
  output logic             uart_hit,
  output logic             spi_hit,
  output logic [NCH-1:0]   chan
);

  int unsigned sel_u;
  int unsigned uoff;
  int unsigned soff;

  always_comb begin
    sel_u    = 32'(cur_sel);
    uart_hit = in_window(sel_u, 32'(UART_BASE), unsigned'(NCH));
    spi_hit  = !uart_hit && in_window(sel_u, 32'(SPI_BASE), unsigned'(NCH));
    uoff     = sel_u - 32'(UART_BASE);
    soff     = sel_u - 32'(SPI_BASE);
    chan     = '0;
    for (int i = 0; i < NCH; i++) begin
      chan[i] = (uart_hit && (uoff == unsigned'(i))) || (spi_hit && (soff == unsigned'(i)));
    end
  end

endmodule

// File: rtl/fifo_route_switch.sv
// Routes one of NCH channel FIFOs to UART or SPI; route changes pass a guard window (stats: FIFO_ROUTE_STATS_EN).
// Latency: strobes combinational, uart_out/spi_out/uart_full registered (1 cycle).
// Backpressure: all FIFO strobes held low while busy; host strobes seen then are dropped and flagged.
module fifo_route_switch
  import fifo_route_pkg::*;
#(
  parameter int                NCH       = 4,
  parameter int                DATA_W    = 16,
  parameter int                SEL_W     = 8,
  parameter logic [SEL_W-1:0]  UART_BASE = SEL_W'(DEF_UART_BASE),
  parameter logic [SEL_W-1:0]  SPI_BASE  = SEL_W'(DEF_SPI_BASE),
  parameter logic [DATA_W-1:0] DEF_WORD  = DATA_W'(16'h1000),
  parameter int                GUARD     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEL_W-1:0]      upr,
  input  logic                  upr_we,
  input  logic [NCH*DATA_W-1:0] data_in,
  input  logic [NCH-1:0]        fifo_full,
  output logic [NCH-1:0]        fifo_wr,
  output logic [NCH-1:0]        fifo_rd,
  input  logic                  uart_wr_en,
  input  logic                  uart_rd_en,
  input  logic                  spi_wr_en,
  input  logic                  spi_clr,
  output logic [DATA_W-1:0]     uart_out,
  output logic [DATA_W-1:0]     spi_out,
  output logic                  uart_full,
  output logic                  busy,
  output logic                  route_err,
  output logic [15:0]           uart_cnt,
  output logic [15:0]           spi_cnt
);

  localparam int               GCNT_W    = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [GCNT_W-1:0] GCNT_INIT = GCNT_W'(GUARD - 1);
  localparam logic [SEL_W-1:0]  NO_SEL    = SEL_W'(NO_ROUTE);

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    cur_sel, cur_sel_d;
  logic [SEL_W-1:0]    pend_q, pend_d;
  logic [GCNT_W-1:0]   gcnt_q, gcnt_d;
  logic                err_d;

  logic                uart_hit, spi_hit;
  logic [NCH-1:0]      chan;
  logic                run, host_any, wr_req, rd_req;
  logic [DATA_W-1:0]   sel_dat, uart_dat_d, spi_dat_d;
  logic                sel_full, uart_full_d;

  fifo_route_decode #(
    .NCH       (NCH),
    .SEL_W     (SEL_W),
    .UART_BASE (UART_BASE),
    .SPI_BASE  (SPI_BASE)
  ) u_decode (
    .cur_sel  (cur_sel),
    .uart_hit (uart_hit),
    .spi_hit  (spi_hit),
    .chan     (chan)
  );

  assign run      = (state_q == RUN);
  assign host_any = uart_wr_en | uart_rd_en | spi_wr_en | spi_clr;
  assign wr_req   = (uart_hit & uart_wr_en) | (spi_hit & spi_wr_en);
  assign rd_req   = (uart_hit & uart_rd_en) | (spi_hit & spi_clr);
  assign fifo_wr  = (run && wr_req) ? chan : '0;
  assign fifo_rd  = (run && rd_req) ? chan : '0;

  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel;
    pend_d    = pend_q;
    gcnt_d    = gcnt_q;
    err_d     = route_err;
    busy      = 1'b0;
    unique case (state_q)
      RUN: begin
        if (upr_we && (upr != cur_sel)) begin
          pend_d  = upr;
          gcnt_d  = GCNT_INIT;
          state_d = HOLD;
        end
      end
      HOLD: begin
        busy = 1'b1;
        if (host_any) err_d = 1'b1;
        // A fresh write always wins over an expiring guard.
        if (upr_we) begin
          pend_d = upr;
          gcnt_d = GCNT_INIT;
        end else if (gcnt_q == '0) begin
          cur_sel_d = pend_q;
          state_d   = RUN;
          if (!sel_valid(32'(pend_q), 32'(UART_BASE), 32'(SPI_BASE), unsigned'(NCH)))
            err_d = 1'b1;
        end else begin
          gcnt_d = gcnt_q - GCNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    sel_dat     = '0;
    sel_full    = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (chan[i]) begin
        sel_dat  = data_in[i*DATA_W +: DATA_W];
        sel_full = fifo_full[i];
      end
    end
    uart_dat_d  = uart_hit ? sel_dat : DEF_WORD;
    uart_full_d = uart_hit & sel_full;
    spi_dat_d   = spi_hit ? sel_dat : DEF_WORD;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      cur_sel   <= NO_SEL;
      pend_q    <= NO_SEL;
      gcnt_q    <= '0;
      route_err <= 1'b0;
      uart_out  <= DEF_WORD;
      spi_out   <= DEF_WORD;
      uart_full <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_sel   <= cur_sel_d;
      pend_q    <= pend_d;
      gcnt_q    <= gcnt_d;
      route_err <= err_d;
      uart_out  <= uart_dat_d;
      spi_out   <= spi_dat_d;
      uart_full <= uart_full_d;
    end
  end

`ifdef FIFO_ROUTE_STATS_EN
  logic [15:0] uart_cnt_q, spi_cnt_q;
  logic        route_apply;

  assign route_apply = (state_q == HOLD) && (state_d == RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      uart_cnt_q <= '0;
      spi_cnt_q  <= '0;
    end else if (route_apply) begin
      uart_cnt_q <= '0;
      spi_cnt_q  <= '0;
    end else begin
      if (run && uart_hit && (uart_wr_en | uart_rd_en) && (uart_cnt_q != 16'hFFFF))
        uart_cnt_q <= uart_cnt_q + 16'd1;
      if (run && spi_hit && (spi_wr_en | spi_clr) && (spi_cnt_q != 16'hFFFF))
        spi_cnt_q <= spi_cnt_q + 16'd1;
    end
  end

  assign uart_cnt = uart_cnt_q;
  assign spi_cnt  = spi_cnt_q;
`else
  assign uart_cnt = '0;
  assign spi_cnt  = '0;
`endif

endmodule
